// File: rtl/serial_subtractor_ctrl_pkg.sv
// serial_subtractor_ctrl_pkg: shared state encodings, default width and counter sizing
package serial_subtractor_ctrl_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int DEF_W = 4;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// serial_subtractor_ctrl_if: start/done request bus between requester and serial subtractor
interface serial_subtractor_ctrl_if #(parameter int W = 4);
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_ready;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_borrow_out;
  modport master (output i_start, i_a, i_b, input o_ready, o_busy, o_done, o_diff, o_borrow_out);
  modport slave  (input i_start, i_a, i_b, output o_ready, o_busy, o_done, o_diff, o_borrow_out);
endinterface

// File: rtl/serial_subtractor_ctrl_cell.sv
// serial_subtractor_ctrl_cell: 1-bit full subtractor built from two half-subtractor stages
module serial_subtractor_ctrl_cell (
  input  logic i_ai,
  input  logic i_bi,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  logic w_d1, w_b1, w_b2;
  assign w_d1   = i_ai ^ i_bi;
  assign w_b1   = ~i_ai & i_bi;
  assign o_d    = w_d1 ^ i_bin;
  assign w_b2   = ~w_d1 & i_bin;
  assign o_bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial unsigned subtractor, one bit per clock, start/done handshake
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input logic                  clk,
  input logic                  rst,
  serial_subtractor_ctrl_if.slave bus
);
  localparam int CW = cnt_w(W);
  logic [1:0]    r_state, w_next;
  logic [W-1:0]  r_a, r_b, r_res, r_diff, w_res;
  logic          r_bor, r_bout, w_d, w_bout, w_last;
  logic [CW-1:0] r_cnt;
  serial_subtractor_ctrl_cell u_cell (
    .i_ai  (r_a[0]),
    .i_bi  (r_b[0]),
    .i_bin (r_bor),
    .o_d   (w_d),
    .o_bout(w_bout)
  );
  assign w_last = r_cnt == CW'(W - 1);
  assign w_res  = (r_res >> 1) | (W'(w_d) << (W - 1));
  // next state; the unused encoding falls back to IDLE
  always_comb
    w_next = (r_state == S_IDLE)  ? (bus.i_start ? S_SHIFT : S_IDLE) :
             (r_state == S_SHIFT) ? (w_last ? S_DONE : S_SHIFT) : S_IDLE;
  // FSM, operand shifters, borrow FF, counter and held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_bor   <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.i_start) begin
        r_a   <= bus.i_a;
        r_b   <= bus.i_b;
        r_res <= '0;
        r_bor <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= w_res;
        r_bor <= w_bout;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_diff <= w_res;
          r_bout <= w_bout;
        end
      end
    end
  end
  assign bus.o_ready      = r_state == S_IDLE;
  assign bus.o_busy       = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign bus.o_done       = r_state == S_DONE;
  assign bus.o_diff       = r_diff;
  assign bus.o_borrow_out = r_bout;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed and exhaustive checks of the serial subtractor against a timing/arithmetic model
module tb_serial_subtractor_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  int m_cnt;
  logic [W-1:0] m_diff, m_pd;
  logic m_bor, m_pb;
  serial_subtractor_ctrl_if #(.W(W)) bif ();
  serial_subtractor_ctrl #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: an accepted start makes the block busy for W+1 cycles, the last of which is the done cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_diff <= '0;
      m_bor  <= 1'b0;
    end else if (m_cnt == 0) begin
      if (bif.i_start) begin
        m_cnt <= W + 1;
        m_pd  <= W'((int'(bif.i_a) - int'(bif.i_b)) & ((1 << W) - 1));
        m_pb  <= int'(bif.i_a) < int'(bif.i_b);
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_diff <= m_pd;
        m_bor  <= m_pb;
      end
    end
  end
  // compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", bif.o_ready, m_cnt == 0);
      chk("busy", bif.o_busy, m_cnt != 0);
      chk("done", bif.o_done, m_cnt == 1);
      chk("ready_busy_compl", bif.o_ready ^ bif.o_busy, 1);
      chk("diff", bif.o_diff, m_diff);
      chk("borrow_out", bif.o_borrow_out, m_bor);
      if (bif.o_done) n_done++;
    end
  end
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    bif.i_a = a;
    bif.i_b = b;
    bif.i_start = 1'b1;
    @(negedge clk);
    bif.i_start = 1'b0;
    lat = -1;
    for (int i = 0; i < 3 * W; i++) begin
      if (bif.o_done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk("latency", lat, W);
    @(negedge clk);
  endtask
  task automatic op_lit(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ed, input logic eb);
    int lat;
    run_op(a, b, lat);
    chk("lit_diff", bif.o_diff, ed);
    chk("lit_borrow", bif.o_borrow_out, eb);
  endtask
  initial begin
    int lat, nd, last;
    bif.i_start = 1'b0;
    bif.i_a = '0;
    bif.i_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bif.o_ready, 1);
    chk("rst_busy", bif.o_busy, 0);
    chk("rst_done", bif.o_done, 0);
    chk("rst_diff", bif.o_diff, 0);
    chk("rst_borrow", bif.o_borrow_out, 0);
    rst = 1'b0;
    op_lit(4'd9, 4'd3, 4'd6, 1'b0);
    op_lit(4'd3, 4'd5, 4'hE, 1'b1);
    op_lit(4'd0, 4'd0, 4'd0, 1'b0);
    op_lit(4'd15, 4'd0, 4'd15, 1'b0);
    op_lit(4'd0, 4'd15, 4'd1, 1'b1);
    op_lit(4'd15, 4'd15, 4'd0, 1'b0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), lat);
        chk("exh_diff", bif.o_diff, (a - b) & 15);
        chk("exh_borrow", bif.o_borrow_out, a < b);
      end
    nd = n_done;
    @(negedge clk);
    bif.i_a = 4'd12;
    bif.i_b = 4'd7;
    bif.i_start = 1'b1;
    @(negedge clk);
    bif.i_a = 4'd1;
    bif.i_b = 4'd1;
    repeat (W) @(negedge clk);
    chk("t4_done_now", bif.o_done, 1);
    bif.i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_diff", bif.o_diff, 5);
    chk("t4_borrow", bif.o_borrow_out, 0);
    chk("t4_one_done", n_done - nd, 1);
    @(negedge clk);
    bif.i_a = 4'd9;
    bif.i_b = 4'd3;
    bif.i_start = 1'b1;
    @(negedge clk);
    bif.i_start = 1'b0;
    @(negedge clk);
    nd = n_done;
    #1 rst = 1'b1;
    #1;
    chk("t5_ready", bif.o_ready, 1);
    chk("t5_busy", bif.o_busy, 0);
    chk("t5_done", bif.o_done, 0);
    chk("t5_diff", bif.o_diff, 0);
    chk("t5_borrow", bif.o_borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    chk("t5_no_done", n_done - nd, 0);
    op_lit(4'd8, 4'd1, 4'd7, 1'b0);
    @(negedge clk);
    bif.i_a = 4'd6;
    bif.i_b = 4'd2;
    bif.i_start = 1'b1;
    last = -1;
    nd = n_done;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (bif.o_done) begin
        if (last >= 0) chk("t6_period", i - last, W + 2);
        chk("t6_diff", bif.o_diff, 4);
        last = i;
      end
    end
    chk("t6_count", n_done - nd, 4);
    bif.i_start = 1'b0;
    repeat (2 * W) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 500000", $time);
    $fatal(1);
  end
endmodule
